// File: rtl/serial_decoder_pkg.sv
// rtl/serial_decoder_pkg.sv - shared types and constants for the serial decoder scheduler
//
// Purpose: scheduler state encoding, symbol width and the symbol the triplet
// decoder is expected to flag.
// Ports: none (package).

package serial_decoder_pkg;

  localparam int SYM_W = 3;

  // The triplet decoder flags an error exactly when it sees three ones.
  localparam logic [SYM_W-1:0] ERROR_SYMBOL = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BIT0 = 3'd1,
    ST_BIT1 = 3'd2,
    ST_BIT2 = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // True while a symbol is being shifted into the decoder.
  function automatic logic is_bit_state(input state_t s);
    return (s == ST_BIT0) || (s == ST_BIT1) || (s == ST_BIT2);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with internal rotation pointer
//
// Purpose: picks the first asserted request starting at the pointer with
// wrap-around; the pointer moves past the winner when advance is strobed.
// Ports:
//   clk       in  system clock
//   n_reset   in  synchronous active-low reset, pointer to 0
//   req       in  N request lines
//   advance   in  commit the current winner and rotate the pointer
//   grant     out one-hot winner (all zero when no request)
//   grant_id  out index of the winner
//   any       out at least one request present

module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  logic [ID_W-1:0] ptr;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N) s = s - N;
    return s[ID_W-1:0];
  endfunction

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[wrap_add(ptr, k)]) begin
        any      = 1'b1;
        grant_id = wrap_add(ptr, k);
      end
    end
    if (any) grant[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= wrap_add(grant_id, 1);
    end
  end

endmodule

// File: rtl/serial_triplet_decoder.sv
// rtl/serial_triplet_decoder.sv - 3-bit serial sequence checker shared by the scheduler
//
// Purpose: consumes one bit per cycle after reset and raises error while the
// third bit is on in_bit if all three bits are one.
// Ports:
//   clk      in  system clock
//   n_reset  in  synchronous active-low reset, returns the checker to START
//   in_bit   in  serial input bit
//   error    out combinational flag, valid during the third bit

module serial_triplet_decoder (
  input  logic clk,
  input  logic n_reset,
  input  logic in_bit,
  output logic error
);

  typedef enum logic [1:0] {
    D_START = 2'd0,
    D_ONE   = 2'd1,
    D_TWO   = 2'd2,
    D_DONE  = 2'd3
  } dec_state_t;

  dec_state_t st;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      st <= D_START;
    end else begin
      case (st)
        D_START: st <= in_bit ? D_ONE : D_DONE;
        D_ONE:   st <= in_bit ? D_TWO : D_DONE;
        default: st <= D_DONE;
      endcase
    end
  end

  // Two ones already seen and the third bit is on the wire.
  assign error = (st == D_TWO) && in_bit;

endmodule

// File: rtl/serial_decoder_scheduler.sv
// rtl/serial_decoder_scheduler.sv - round-robin sharing of one serial triplet decoder
//
// Purpose: accepts 3-bit symbols from NUM_REQ requesters, shifts each into the
// external decoder bit 0 first, captures its error flag on the third bit,
// returns a tagged response and cross-checks the decoder against ERROR_SYMBOL.
// Ports:
//   clk, n_reset       clock, synchronous active-low reset
//   req_valid/ready    per-requester handshake, ready is a one-hot grant
//   req_symbol         packed symbols, requester i at [3i+2:3i]
//   dec_n_reset        decoder reset, held low outside BIT0..BIT2
//   dec_in_bit         serial bit to the decoder
//   dec_error          decoder error flag (combinational on decoder side)
//   resp_valid         one-cycle response pulse
//   resp_id/resp_error requester index and captured decoder flag
//   error_count        saturating count of error responses
//   fault              sticky decoder/reference disagreement

module serial_decoder_scheduler
  import serial_decoder_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [SYM_W*NUM_REQ-1:0] req_symbol,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     dec_n_reset,
  output logic                     dec_in_bit,
  input  logic                     dec_error,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic                     resp_error,
  output logic [CNT_W-1:0]         error_count,
  output logic                     fault
);

  state_t          state;
  logic [SYM_W-1:0] sym;
  logic [ID_W-1:0]  cur_id;

  logic               arb_en;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [SYM_W-1:0]   sel_sym;

  // Arbitrate only between symbols, and never while reset is asserted, so a
  // grant always coincides with an accepted handshake.
  assign arb_en  = n_reset && ((state == ST_IDLE) || (state == ST_RESP));
  assign arb_req = req_valid & {NUM_REQ{arb_en}};

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk      (clk),
    .n_reset  (n_reset),
    .req      (arb_req),
    .advance  (arb_en),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  assign req_ready = grant;
  assign sel_sym   = req_symbol[int'(grant_id)*SYM_W +: SYM_W];

  // The decoder sits in reset during every IDLE/RESP cycle, so each symbol
  // starts from its START state.
  assign dec_n_reset = n_reset && is_bit_state(state);

  always_comb begin
    dec_in_bit = 1'b0;
    case (state)
      ST_BIT0: dec_in_bit = sym[0];
      ST_BIT1: dec_in_bit = sym[1];
      ST_BIT2: dec_in_bit = sym[2];
      default: dec_in_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= ST_IDLE;
      sym         <= '0;
      cur_id      <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_error  <= 1'b0;
      error_count <= '0;
      fault       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (grant_any) begin
            sym    <= sel_sym;
            cur_id <= grant_id;
            state  <= ST_BIT0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BIT0: state <= ST_BIT1;
        ST_BIT1: state <= ST_BIT2;
        ST_BIT2: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_id    <= cur_id;
          resp_error <= dec_error;
          fault      <= fault | (dec_error != (sym == ERROR_SYMBOL));
          if (dec_error && (error_count != {CNT_W{1'b1}}))
            error_count <= error_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_decoder_scheduler.sv
// tb/tb_serial_decoder_scheduler.sv - directed self-checking bench for serial_decoder_scheduler

module tb_serial_decoder_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 8;

  logic                 clk = 1'b0;
  logic                 n_reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_symbol;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 dec_n_reset;
  logic                 dec_in_bit;
  logic                 dec_error;
  logic                 dec_error_raw;
  logic                 force_dec_low;
  logic                 resp_valid;
  logic [ID_W-1:0]      resp_id;
  logic                 resp_error;
  logic [CNT_W-1:0]     error_count;
  logic                 fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_decoder_scheduler #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .req_valid   (req_valid),
    .req_symbol  (req_symbol),
    .req_ready   (req_ready),
    .dec_n_reset (dec_n_reset),
    .dec_in_bit  (dec_in_bit),
    .dec_error   (dec_error),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_error  (resp_error),
    .error_count (error_count),
    .fault       (fault)
  );

  serial_triplet_decoder u_dec (
    .clk     (clk),
    .n_reset (dec_n_reset),
    .in_bit  (dec_in_bit),
    .error   (dec_error_raw)
  );

  assign dec_error = force_dec_low ? 1'b0 : dec_error_raw;

  task automatic assert_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single requester sends one symbol from IDLE; ends 4ns into the following IDLE cycle.
  task automatic run_symbol(input int id, input logic [2:0] sym, input logic exp_err,
                            input logic [7:0] exp_cnt, input logic exp_fault);
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    req_valid = onehot;
    req_symbol[id*3 +: 3] = sym;
    #3;
    assert_eq("ready_grant", req_ready, onehot);
    tick;
    req_valid = '0;
    #3;
    assert_eq("dec_rst_bit0", dec_n_reset, 1'b1);
    assert_eq("bit0", dec_in_bit, sym[0]);
    tick; #3;
    assert_eq("bit1", dec_in_bit, sym[1]);
    tick; #3;
    assert_eq("bit2", dec_in_bit, sym[2]);
    assert_eq("ready_busy", req_ready, 4'b0000);
    assert_eq("no_resp_busy", resp_valid, 1'b0);
    tick; #3;
    assert_eq("resp_valid", resp_valid, 1'b1);
    assert_eq("resp_id", resp_id, id[1:0]);
    assert_eq("resp_error", resp_error, exp_err);
    assert_eq("error_count", error_count, exp_cnt);
    assert_eq("fault", fault, exp_fault);
    assert_eq("dec_rst_resp", dec_n_reset, 1'b0);
    tick; #3;
    assert_eq("resp_pulse_end", resp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_reset       = 1'b0;
    req_valid     = 4'b0001;
    req_symbol    = '0;
    force_dec_low = 1'b0;

    // Reset state; ready stays low even with a valid request present.
    tick; tick; #3;
    assert_eq("rst_ready", req_ready, 4'b0000);
    assert_eq("rst_dec_n_reset", dec_n_reset, 1'b0);
    assert_eq("rst_resp_valid", resp_valid, 1'b0);
    assert_eq("rst_resp_id", resp_id, 2'd0);
    assert_eq("rst_resp_error", resp_error, 1'b0);
    assert_eq("rst_count", error_count, 8'd0);
    assert_eq("rst_fault", fault, 1'b0);

    // First symbol: 111 flags an error.
    n_reset   = 1'b1;
    req_valid = '0;
    run_symbol(0, 3'b111, 1'b1, 8'd1, 1'b0);

    // Leading zero, and trailing zero: no error.
    run_symbol(2, 3'b011, 1'b0, 8'd1, 1'b0);
    run_symbol(2, 3'b110, 1'b0, 8'd1, 1'b0);

    // All requesters continuously valid with 111: strict rotation, saturation.
    n_reset = 1'b0;
    tick;
    n_reset    = 1'b1;
    req_symbol = 12'hFFF;
    req_valid  = 4'hF;
    #3;
    assert_eq("rot_first_grant", req_ready, 4'b0001);
    for (int k = 0; k < 260; k++) begin
      tick; tick; #3;
      assert_eq("rot_busy_ready", req_ready, 4'b0000);
      tick; tick; #3;
      assert_eq("rot_resp_valid", resp_valid, 1'b1);
      assert_eq("rot_resp_id", resp_id, k % 4);
      assert_eq("rot_resp_error", resp_error, 1'b1);
      assert_eq("rot_count", error_count, (k + 1 > 255) ? 255 : k + 1);
      assert_eq("rot_next_grant", req_ready, 32'd1 << ((k + 1) % 4));
    end
    req_valid = '0;
    n_reset   = 1'b0;
    tick;
    n_reset = 1'b1;
    #3;

    // Pointer at 2 with requesters 0 and 3 valid: 3 then 0; idle gap keeps pointer.
    req_symbol = '0;
    run_symbol(1, 3'b000, 1'b0, 8'd0, 1'b0);
    req_valid = 4'b1001;
    #3;
    assert_eq("ptr2_grant3", req_ready, 4'b1000);
    tick; tick; tick; tick; #3;
    assert_eq("ptr_resp3", resp_id, 2'd3);
    assert_eq("ptr_grant0", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    tick; tick; tick; #3;
    assert_eq("ptr_resp0_valid", resp_valid, 1'b1);
    assert_eq("ptr_resp0", resp_id, 2'd0);
    tick; tick; tick;
    req_valid = 4'b1001;
    #3;
    assert_eq("ptr_after_gap", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    tick; tick; tick; tick; #3;

    // Reset during BIT1 aborts the symbol silently.
    n_reset = 1'b0;
    tick;
    n_reset    = 1'b1;
    req_symbol = 12'h007;
    req_valid  = 4'b0001;
    #3;
    assert_eq("abort_grant", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    tick;
    n_reset   = 1'b0;
    req_valid = 4'b0001;
    #3;
    assert_eq("abort_dec_rst", dec_n_reset, 1'b0);
    assert_eq("abort_ready", req_ready, 4'b0000);
    tick;
    n_reset   = 1'b1;
    req_valid = '0;
    #3;
    assert_eq("abort_no_resp0", resp_valid, 1'b0);
    tick; #3;
    assert_eq("abort_no_resp1", resp_valid, 1'b0);
    tick; #3;
    assert_eq("abort_no_resp2", resp_valid, 1'b0);
    run_symbol(0, 3'b111, 1'b1, 8'd1, 1'b0);

    // Decoder forced silent on 111: sticky fault until reset.
    force_dec_low = 1'b1;
    run_symbol(1, 3'b111, 1'b0, 8'd1, 1'b1);
    force_dec_low = 1'b0;
    run_symbol(2, 3'b011, 1'b0, 8'd1, 1'b1);
    run_symbol(3, 3'b111, 1'b1, 8'd2, 1'b1);
    n_reset = 1'b0;
    tick; #3;
    assert_eq("fault_cleared", fault, 1'b0);
    n_reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
